// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one txuartlite byte transmitter between NUM_REQ byte sources.
// A grant lasts one message: released on req_last, after MAX_BURST bytes, or after IDLE_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_wr,
    input  logic                          tx_busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2((MAX_BURST > 2) ? MAX_BURST : 2) + 1;
    localparam int IDLE_W = $clog2((IDLE_TIMEOUT > 2) ? IDLE_TIMEOUT : 2) + 1;
    localparam logic [BEAT_W-1:0]  BURST_LIM = BEAT_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_LIM  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {ARB, SEND, GUARD} state_t;

    state_t                state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      arb_idx;
    logic [IDX_W-1:0]      cand;
    logic                  arb_hit;
    logic                  rel;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BEAT_W-1:0]     beat_nxt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [IDLE_W-1:0]     idle_nxt;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan starts just after the previous owner so every requester gets a turn.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Counters saturate instead of wrapping when their limit is 0 (unlimited).
    assign beat_nxt = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
    assign idle_nxt = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;

    // NOTE: req_ready is combinational on tx_busy so a byte is taken the same cycle the UART frees up.
    assign req_ready = (state == SEND && !tx_busy) ? grant : '0;

    // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ARB;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            tx_wr    <= 1'b0;
            tx_data  <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            rel      <= 1'b0;
        end else begin
            tx_wr <= 1'b0;
            case (state)
                ARB: begin
                    if (arb_hit) begin
                        owner    <= arb_idx;
                        grant    <= ONE_HOT0 << arb_idx;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= SEND;
                    end else begin
                        grant <= '0;
                    end
                end
                SEND: begin
                    if (req_valid[owner] && !tx_busy) begin
                        tx_data  <= data_arr[owner];
                        tx_wr    <= 1'b1;
                        beat_cnt <= beat_nxt;
                        rel      <= req_last[owner] || ((MAX_BURST != 0) && (beat_nxt == BURST_LIM));
                        idle_cnt <= '0;
                        state    <= GUARD;
                    end else if (!req_valid[owner]) begin
                        idle_cnt <= idle_nxt;
                        if ((IDLE_TIMEOUT != 0) && (idle_nxt == IDLE_LIM)) begin
                            grant  <= '0;
                            rr_ptr <= owner;
                            state  <= ARB;
                        end
                    end
                end
                GUARD: begin
                    // tx_busy only rises the cycle after tx_wr, so it is not looked at here.
                    if (rel) begin
                        grant  <= '0;
                        rr_ptr <= owner;
                        state  <= ARB;
                    end else begin
                        state <= SEND;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table for a single message, then queued-requester
// sequences for round robin, burst limit, idle timeout, long busy and reset mid-transfer.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;

    logic        use_model;
    logic        man_busy;
    int          busy_len;
    int          busy_cnt;

    int errors = 0;
    int checks = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [9:0]  log_q[$];
    logic [9:0]  exp_q[$];
    int          log_cyc[$];
    int          cyc = 0;
    int          overlap;
    int          idle_obs;
    int          rdy_bad;
    logic [1:0]  acc;

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] last;
        logic [7:0] d0;
        logic       busy;
        logic [1:0] e_grant;
        logic [1:0] e_ready;
        logic       e_wr;
        logic [7:0] e_txd;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(4), .IDLE_TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
    );

    // txuartlite stand-in: busy rises the cycle after tx_wr and lasts busy_len cycles.
    assign tx_busy = use_model ? (busy_cnt != 0) : man_busy;
    always @(posedge clk) begin
        if (!reset)            busy_cnt <= 0;
        else if (tx_wr)        busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        cyc++;
        if (tx_wr === 1'b1) begin
            log_q.push_back({grant, tx_data});
            log_cyc.push_back(cyc);
            if (tx_busy) overlap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        acc       = '0;
        man_busy  = 1'b0;
        repeat (3) @(negedge clk);
        q0.delete();
        q1.delete();
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
        overlap  = 0;
        idle_obs = 0;
        rdy_bad  = 0;
        reset    = 1'b1;
    endtask

    // One cycle of the queued requesters: pop what was accepted, present the next head.
    task automatic step();
        logic [8:0] h0;
        logic [8:0] h1;
        @(negedge clk);
        if (acc[0] && q0.size() != 0) q0.delete(0);
        if (acc[1] && q1.size() != 0) q1.delete(0);
        h0 = (q0.size() != 0) ? q0[0] : 9'h000;
        h1 = (q1.size() != 0) ? q1[0] : 9'h000;
        req_valid = {q1.size() != 0, q0.size() != 0};
        req_data  = {h1[7:0], h0[7:0]};
        req_last  = {h1[8], h0[8]};
        #1;
        acc = req_valid & req_ready;
        if (grant == 2'b01 && !req_valid[0] && !tx_wr) idle_obs++;
        if ((req_ready & ~grant) != 0 || (req_ready != 0 && tx_busy)) rdy_bad++;
    endtask

    task automatic run_queues();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        repeat (10) step();
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), log_q[i], exp_q[i]);
    endtask

    initial begin
        // {valid, last, d0, busy | grant, ready, tx_wr, tx_data}
        vecs[0]  = '{2'b01, 2'b00, 8'h41, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00};
        vecs[1]  = '{2'b01, 2'b00, 8'h41, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00};
        vecs[2]  = '{2'b01, 2'b00, 8'h42, 1'b0, 2'b01, 2'b00, 1'b1, 8'h41};
        vecs[3]  = '{2'b01, 2'b00, 8'h42, 1'b1, 2'b01, 2'b00, 1'b0, 8'h41};
        vecs[4]  = '{2'b01, 2'b00, 8'h42, 1'b1, 2'b01, 2'b00, 1'b0, 8'h41};
        vecs[5]  = '{2'b01, 2'b00, 8'h42, 1'b0, 2'b01, 2'b01, 1'b0, 8'h41};
        vecs[6]  = '{2'b01, 2'b01, 8'h43, 1'b0, 2'b01, 2'b00, 1'b1, 8'h42};
        vecs[7]  = '{2'b01, 2'b01, 8'h43, 1'b1, 2'b01, 2'b00, 1'b0, 8'h42};
        vecs[8]  = '{2'b01, 2'b01, 8'h43, 1'b0, 2'b01, 2'b01, 1'b0, 8'h42};
        vecs[9]  = '{2'b00, 2'b00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h43};
        vecs[10] = '{2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h43};
        vecs[11] = '{2'b00, 2'b00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h43};

        use_model = 1'b0;
        busy_len  = 2;
        do_reset();
        #1;
        check("reset_grant", grant, 2'b00);
        check("reset_ready", req_ready, 2'b00);
        check("reset_tx_wr", tx_wr, 1'b0);
        check("reset_tx_data", tx_data, 8'h00);

        // Single requester, three-byte message, busy driven by the table.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = vecs[i].valid;
            req_last  = vecs[i].last;
            req_data  = {8'h00, vecs[i].d0};
            man_busy  = vecs[i].busy;
            #1;
            check($sformatf("t1_row%0d", i), {grant, req_ready, tx_wr, tx_data},
                  {vecs[i].e_grant, vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_txd});
        end

        // Round robin between two 2-byte messages, then wrap back to requester 0.
        use_model = 1'b1;
        busy_len  = 3;
        do_reset();
        q0 = '{9'h0A0, 9'h1A1, 9'h0C0, 9'h1C1};
        q1 = '{9'h0B0, 9'h1B1};
        exp_q = '{10'h1A0, 10'h1A1, 10'h2B0, 10'h2B1, 10'h1C0, 10'h1C1};
        run_queues();
        check_log("t2_rr");
        check("t2_grant_end", grant, 2'b00);
        check("t2_overlap", overlap, 0);

        // Burst limit of 4 splits a 6-byte message around requester 1.
        busy_len = 2;
        do_reset();
        q0 = '{9'h0D0, 9'h0D1, 9'h0D2, 9'h0D3, 9'h0D4, 9'h1D5};
        q1 = '{9'h0E0, 9'h1E1};
        exp_q = '{10'h1D0, 10'h1D1, 10'h1D2, 10'h1D3, 10'h2E0, 10'h2E1, 10'h1D4, 10'h1D5};
        run_queues();
        check_log("t3_burst");
        check("t3_overlap", overlap, 0);

        // Owner goes quiet mid-message: released after exactly 20 idle cycles.
        do_reset();
        q0 = '{9'h0F0};
        q1 = '{9'h167};
        exp_q = '{10'h1F0, 10'h267};
        run_queues();
        check_log("t4_idle");
        check("t4_idle_cycles", idle_obs, 20);
        check("t4_grant_end", grant, 2'b00);

        // Long busy: no ready and no second write until the UART frees up.
        busy_len = 50;
        do_reset();
        q0 = '{9'h048, 9'h149};
        exp_q = '{10'h148, 10'h149};
        run_queues();
        check_log("t5_busy");
        if (log_cyc.size() >= 2) check("t5_write_gap", log_cyc[1] - log_cyc[0], 52);
        else check("t5_write_gap", log_cyc.size(), 2);
        check("t5_ready_during_busy", rdy_bad, 0);
        check("t5_overlap", overlap, 0);

        // Reset while in GUARD with the UART busy.
        use_model = 1'b0;
        do_reset();
        @(negedge clk);
        req_valid = 2'b10;
        req_last  = 2'b10;
        req_data  = {8'h66, 8'h00};
        @(negedge clk);
        #1;
        check("t6_ready_req1", req_ready, 2'b10);
        @(negedge clk);
        #1;
        check("t6_guard_wr", {tx_wr, tx_data}, {1'b1, 8'h66});
        man_busy  = 1'b1;
        reset     = 1'b0;
        req_valid = 2'b11;
        req_last  = 2'b11;
        req_data  = {8'h66, 8'h55};
        @(negedge clk);
        #1;
        check("t6_reset_outputs", {grant, req_ready, tx_wr, tx_data}, 19'h0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t6_grant_req0", grant, 2'b01);
        check("t6_ready_busy", req_ready, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("t6_hold%0d", i), {tx_wr, req_ready}, 3'b000);
        end
        @(negedge clk);
        man_busy = 1'b0;
        #1;
        check("t6_ready_free", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("t6_write", {grant, tx_wr, tx_data}, {2'b01, 1'b1, 8'h55});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
